// File: rtl/alu_issue_ctrl.sv
// Issue/collect controller in front of the Alu: buffers up to two operand packets, loads the
// Alu latch, waits a fixed settle time, and registers Z onto a valid/ready result port.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned INST_W     = 4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [INST_W-1:0] in_inst,
  input  logic              in_sel,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [INST_W-1:0] alu_inst,
  output logic              alu_sel,
  output logic              alu_en,
  input  logic [WIDTH-1:0]  alu_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_z,
  output logic [INST_W-1:0] out_inst,
  output logic              busy
);

  localparam int unsigned EntW = 2 * WIDTH + INST_W + 1;
  localparam logic [3:0] SettleInit = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSettle, StCapt} state_e;

  state_e            state_q;
  logic [EntW-1:0]   fifo_q [2];
  logic [1:0]        count_q;
  logic              rd_q;
  logic [3:0]        settle_q;

  logic              push;
  logic              pop;
  logic              cap_ok;
  logic              wr_idx;
  logic [EntW-1:0]   head;

  // Ready comes from the registered count only, so a full FIFO refuses even on a pop cycle.
  assign in_ready = (count_q != 2'd2);
  assign push     = in_valid & in_ready;
  assign cap_ok   = ~out_valid | out_ready;
  assign pop      = (count_q != 2'd0) &
                    ((state_q == StIdle) | ((state_q == StCapt) & cap_ok));
  assign wr_idx   = rd_q ^ count_q[0];
  assign head     = fifo_q[rd_q];
  assign busy     = (count_q != 2'd0) | (state_q != StIdle) | out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      count_q   <= 2'd0;
      rd_q      <= 1'b0;
      settle_q  <= 4'd0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_inst  <= '0;
      alu_sel   <= 1'b0;
      alu_en    <= 1'b0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_inst  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_idx] <= {in_sel, in_inst, in_b, in_a};
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};

      // Alu operands only move on LOAD entry; EN is a one-cycle pulse marking LOAD.
      if (pop) begin
        rd_q                               <= ~rd_q;
        {alu_sel, alu_inst, alu_b, alu_a}  <= head;
      end
      alu_en <= pop;

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (pop) state_q <= StLoad;
        end
        StLoad: begin
          state_q  <= StSettle;
          settle_q <= SettleInit;
        end
        StSettle: begin
          if (settle_q == 4'd0) state_q <= StCapt;
          else                  settle_q <= settle_q - 4'd1;
        end
        StCapt: begin
          // A capture on the same edge as a consume keeps out_valid set.
          if (cap_ok) begin
            out_z     <= alu_z;
            out_inst  <= alu_inst;
            out_valid <= 1'b1;
            state_q   <= pop ? StLoad : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
